mem_access: RTL

MEM_ACCESS -- requirements
Module: mem_access

---
 rtl/mem_access.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/mem_access.sv
// Byte-serial load/store unit between the execute stage and an 8-bit RAM.
// Sequences 1/2/4-byte accesses, stalls the pipeline and assembles write-back data.
module mem_access (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  aluop_i,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] st_data_i,
  input  logic [4:0]  w_addr_i,
  input  logic        w_req_i,
  input  logic [31:0] w_data_i,
  input  logic [7:0]  mem_din_i,
  output logic [31:0] mem_a_o,
  output logic [7:0]  mem_dout_o,
  output logic        mem_wr_o,
  output logic [4:0]  w_addr_o,
  output logic        w_req_o,
  output logic [31:0] w_data_o,
  output logic        stall_req_o
);

  localparam int unsigned AluOpW = 8;
  localparam int unsigned CntW   = 3;

  localparam logic [AluOpW-1:0] EX_LB  = 8'h10;
  localparam logic [AluOpW-1:0] EX_LH  = 8'h11;
  localparam logic [AluOpW-1:0] EX_LW  = 8'h12;
  localparam logic [AluOpW-1:0] EX_LBU = 8'h13;
  localparam logic [AluOpW-1:0] EX_LHU = 8'h14;
  localparam logic [AluOpW-1:0] EX_SB  = 8'h18;
  localparam logic [AluOpW-1:0] EX_SH  = 8'h19;
  localparam logic [AluOpW-1:0] EX_SW  = 8'h1A;

  typedef enum logic [1:0] {IDLE, LOAD, STORE, DONE} state_t;

  state_t             state_q;
  logic [AluOpW-1:0]  op_q;
  logic [31:0]        addr_q;
  logic [31:0]        sdata_q;
  logic [4:0]         waddr_q;
  logic               wreq_q;
  logic [CntW-1:0]    cnt_q;
  logic [31:0]        data_q;
  logic [1:0]         ld_idx;

  function automatic logic is_load(input logic [AluOpW-1:0] op);
    return (op == EX_LB) || (op == EX_LH) || (op == EX_LW) ||
           (op == EX_LBU) || (op == EX_LHU);
  endfunction

  function automatic logic is_store(input logic [AluOpW-1:0] op);
    return (op == EX_SB) || (op == EX_SH) || (op == EX_SW);
  endfunction

  // Access width in bytes; zero for non-memory operations.
  function automatic logic [CntW-1:0] acc_width(input logic [AluOpW-1:0] op);
    case (op)
      EX_LB, EX_LBU, EX_SB: return 3'd1;
      EX_LH, EX_LHU, EX_SH: return 3'd2;
      EX_LW, EX_SW:         return 3'd4;
      default:              return 3'd0;
    endcase
  endfunction

  // Byte lane for the load capture; counter 4 wraps to lane 3.
  assign ld_idx = cnt_q[1:0] - 2'd1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      op_q    <= '0;
      addr_q  <= '0;
      sdata_q <= '0;
      waddr_q <= '0;
      wreq_q  <= 1'b0;
      cnt_q   <= '0;
      data_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (is_load(aluop_i) || is_store(aluop_i)) begin
            op_q    <= aluop_i;
            addr_q  <= mem_addr_i;
            sdata_q <= st_data_i;
            waddr_q <= w_addr_i;
            wreq_q  <= w_req_i;
            data_q  <= '0;
            cnt_q   <= 3'd1;
            if (is_load(aluop_i))
              state_q <= LOAD;
            else if (acc_width(aluop_i) == 3'd1)
              state_q <= DONE;
            else
              state_q <= STORE;
          end
        end
        LOAD: begin
          case (ld_idx)
            2'd0: data_q[7:0]   <= mem_din_i;
            2'd1: data_q[15:8]  <= mem_din_i;
            2'd2: data_q[23:16] <= mem_din_i;
            default: data_q[31:24] <= mem_din_i;
          endcase
          cnt_q <= cnt_q + 3'd1;
          if (cnt_q == acc_width(op_q))
            state_q <= DONE;
        end
        STORE: begin
          cnt_q <= cnt_q + 3'd1;
          if (cnt_q == acc_width(op_q) - 3'd1)
            state_q <= DONE;
        end
        default: begin
          cnt_q   <= '0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  // RAM port, stall and write-back; all forced low while in reset.
  always_comb begin
    mem_a_o     = '0;
    mem_dout_o  = '0;
    mem_wr_o    = 1'b0;
    w_addr_o    = '0;
    w_req_o     = 1'b0;
    w_data_o    = '0;
    stall_req_o = 1'b0;
    if (!rst) begin
      case (state_q)
        IDLE: begin
          if (is_load(aluop_i) || is_store(aluop_i)) begin
            stall_req_o = 1'b1;
            mem_a_o     = mem_addr_i;
            if (is_store(aluop_i)) begin
              mem_dout_o = st_data_i[7:0];
              mem_wr_o   = 1'b1;
            end
          end else begin
            w_addr_o = w_addr_i;
            w_data_o = w_data_i;
            w_req_o  = w_req_i && (w_addr_i != 5'd0);
          end
        end
        LOAD: begin
          stall_req_o = 1'b1;
          if (cnt_q < acc_width(op_q))
            mem_a_o = addr_q + 32'(cnt_q);
        end
        STORE: begin
          stall_req_o = 1'b1;
          mem_a_o     = addr_q + 32'(cnt_q);
          mem_wr_o    = 1'b1;
          case (cnt_q[1:0])
            2'd0: mem_dout_o = sdata_q[7:0];
            2'd1: mem_dout_o = sdata_q[15:8];
            2'd2: mem_dout_o = sdata_q[23:16];
            default: mem_dout_o = sdata_q[31:24];
          endcase
        end
        default: begin
          if (is_load(op_q)) begin
            w_addr_o = waddr_q;
            w_req_o  = wreq_q && (waddr_q != 5'd0);
            case (op_q)
              EX_LB:   w_data_o = {{24{data_q[7]}}, data_q[7:0]};
              EX_LH:   w_data_o = {{16{data_q[15]}}, data_q[15:0]};
              EX_LBU:  w_data_o = {24'd0, data_q[7:0]};
              EX_LHU:  w_data_o = {16'd0, data_q[15:0]};
              default: w_data_o = data_q;
            endcase
          end
        end
      endcase
    end
  end

endmodule
